// File: rtl/key_event_pkg.sv
// Shared types and parameter checks for the multi-channel key debouncer.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } ch_state_t;

  localparam string POL_LOW  = "LOW";
  localparam string POL_HIGH = "HIGH";

  // Counter widths must hold the largest terminal count they compare against.
  function automatic bit params_legal(input int sync_stages, input int tick_div,
                                      input int tick_w, input int db_ticks,
                                      input int long_ticks, input int cnt_w);
    bit ok;
    ok = (sync_stages >= 2);
    ok = ok && (tick_div >= 1) && (tick_w >= 1) && (tick_w <= 30);
    ok = ok && ((tick_div - 1) < (1 << tick_w));
    ok = ok && (db_ticks >= 1) && (long_ticks > db_ticks);
    ok = ok && (cnt_w >= 1) && (cnt_w <= 30);
    ok = ok && ((long_ticks - 1) < (1 << cnt_w));
    return ok;
  endfunction

endpackage

// File: rtl/key_event_debounce_channel.sv
// One debounce channel: level FSM, long-press timer, event pulses and sticky flags.
module key_event_channel
  import key_event_pkg::*;
#(
  parameter int DB_TICKS   = 5,
  parameter int LONG_TICKS = 1000,
  parameter int CNT_W      = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic tick_i,
  input  logic sts_clr_i,
  output logic data_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_pulse_o,
  output logic press_sts_o,
  output logic release_sts_o,
  output logic long_sts_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_TICKS - 1);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_TICKS - 1);

  ch_state_t        state_q;
  logic [CNT_W-1:0] db_cnt_q;
  logic [CNT_W-1:0] lp_cnt_q;
  logic             long_done_q;
  logic             data_q;
  logic             press_q;
  logic             release_q;
  logic             long_q;
  logic             press_sts_q, press_sts_d;
  logic             release_sts_q, release_sts_d;
  logic             long_sts_q, long_sts_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      lp_cnt_q    <= '0;
      long_done_q <= 1'b0;
      data_q      <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;

      // Long-press timer keeps running through release-wait glitches.
      if ((state_q == PRESSED || state_q == RELEASE_WAIT) && !long_done_q && tick_i) begin
        if (lp_cnt_q == LP_LAST) begin
          long_q      <= 1'b1;
          long_done_q <= 1'b1;
        end else begin
          lp_cnt_q <= lp_cnt_q + 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (raw_i) begin
            state_q  <= PRESS_WAIT;
            db_cnt_q <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!raw_i) begin
            state_q <= IDLE;
          end else if (tick_i) begin
            if (db_cnt_q == DB_LAST) begin
              state_q  <= PRESSED;
              data_q   <= 1'b1;
              press_q  <= 1'b1;
              lp_cnt_q <= '0;
            end else begin
              db_cnt_q <= db_cnt_q + 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!raw_i) begin
            state_q  <= RELEASE_WAIT;
            db_cnt_q <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (raw_i) begin
            state_q <= PRESSED;
          end else if (tick_i) begin
            if (db_cnt_q == DB_LAST) begin
              // Release overrides a long-press threshold landing on this tick.
              state_q     <= IDLE;
              data_q      <= 1'b0;
              release_q   <= 1'b1;
              long_q      <= 1'b0;
              lp_cnt_q    <= '0;
              long_done_q <= 1'b0;
            end else begin
              db_cnt_q <= db_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky bits latch the registered pulse, so a clear in the pulse cycle loses.
  always_comb begin
    press_sts_d   = press_q   | (press_sts_q   & ~sts_clr_i);
    release_sts_d = release_q | (release_sts_q & ~sts_clr_i);
    long_sts_d    = long_q    | (long_sts_q    & ~sts_clr_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      press_sts_q   <= 1'b0;
      release_sts_q <= 1'b0;
      long_sts_q    <= 1'b0;
    end else begin
      press_sts_q   <= press_sts_d;
      release_sts_q <= release_sts_d;
      long_sts_q    <= long_sts_d;
    end
  end

  assign data_o          = data_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign long_pulse_o    = long_q;
  assign press_sts_o     = press_sts_q;
  assign release_sts_o   = release_sts_q;
  assign long_sts_o      = long_sts_q;

endmodule

// File: rtl/key_event_debounce.sv
// Multi-channel key debouncer: input synchroniser, shared tick prescaler,
// per-channel event FSMs and a registered interrupt OR.
module key_event_debounce
  import key_event_pkg::*;
#(
  parameter int    WIDTH       = 2,
  parameter string POLARITY    = "LOW",
  parameter int    SYNC_STAGES = 2,
  parameter int    TICK_DIV    = 50000,
  parameter int    TICK_W      = 16,
  parameter int    DB_TICKS    = 5,
  parameter int    LONG_TICKS  = 1000,
  parameter int    CNT_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_pulse,
  output logic [WIDTH-1:0] press_sts,
  output logic [WIDTH-1:0] release_sts,
  output logic [WIDTH-1:0] long_sts,
  input  logic [WIDTH-1:0] sts_clr,
  output logic             irq
);

  localparam bit ACTIVE_LOW = (POLARITY == POL_LOW);
  localparam bit POL_OK     = (POLARITY == POL_LOW) || (POLARITY == POL_HIGH);
  localparam logic [WIDTH-1:0]  IDLE_LVL  = ACTIVE_LOW ? '1 : '0;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  if (!POL_OK || !params_legal(SYNC_STAGES, TICK_DIV, TICK_W, DB_TICKS, LONG_TICKS, CNT_W))
  begin : g_param_err
    $error("key_event_debounce: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  raw;
  logic [TICK_W-1:0]                 pre_q, pre_d;
  logic                              tick;
  logic                              irq_q;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{IDLE_LVL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
    end
  end

  assign raw = ACTIVE_LOW ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

  assign tick  = (pre_q == TICK_LAST);
  assign pre_d = tick ? '0 : pre_q + TICK_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    key_event_channel #(
      .DB_TICKS  (DB_TICKS),
      .LONG_TICKS(LONG_TICKS),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .raw_i          (raw[g]),
      .tick_i         (tick),
      .sts_clr_i      (sts_clr[g]),
      .data_o         (data_out[g]),
      .press_pulse_o  (press_pulse[g]),
      .release_pulse_o(release_pulse[g]),
      .long_pulse_o   (long_pulse[g]),
      .press_sts_o    (press_sts[g]),
      .release_sts_o  (release_sts[g]),
      .long_sts_o     (long_sts[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |{press_sts, release_sts, long_sts};
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_key_event_debounce.sv
// Randomised and directed bench for key_event_debounce against an event-timing reference model.
module tb_key_event_debounce;

  localparam int W  = 2;
  localparam int TD = 10;
  localparam int DB = 3;
  localparam int LT = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data_in = '1;
  logic [W-1:0] sts_clr = '0;
  logic [W-1:0] data_out, press_pulse, release_pulse, long_pulse;
  logic [W-1:0] press_sts, release_sts, long_sts;
  logic         irq;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_event_debounce #(
    .WIDTH(W), .POLARITY("LOW"), .SYNC_STAGES(2), .TICK_DIV(TD), .TICK_W(4),
    .DB_TICKS(DB), .LONG_TICKS(LT), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(data_out),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse),
    .press_sts(press_sts), .release_sts(release_sts), .long_sts(long_sts),
    .sts_clr(sts_clr), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, $signed(got), $signed(exp), cyc);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference model: a level change is accepted on the DB-th tick after the raw
  // input first disagreed with the level, provided it disagreed continuously.
  // A long press is the LT-th tick after the accepted press, unless released then.
  logic [W-1:0] m_lvl, m_pp, m_rp, m_lp, m_ps, m_rs, m_ls;
  logic         m_irq;
  int           m_run [W];
  int           m_pe  [W];
  bit           m_ld  [W];
  logic [W-1:0] hist [$];
  int           k;
  bit           m_ok = 1'b0;

  function automatic int ticks_in(input int a, input int b);
    return (b + 1) / TD - (a + 1) / TD;
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] r, np, nr, nl;
    bit tk;
    if (reset) begin
      m_lvl = '0; m_pp = '0; m_rp = '0; m_lp = '0;
      m_ps = '0; m_rs = '0; m_ls = '0; m_irq = 1'b0;
      hist.delete();
      hist.push_back('1);
      hist.push_back('1);
      for (int c = 0; c < W; c++) begin
        m_run[c] = -1; m_pe[c] = 0; m_ld[c] = 1'b0;
      end
      k = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      r = ~hist.pop_front();
      hist.push_back(data_in);
      tk = ((k % TD) == TD - 1);
      m_irq = |{m_ps, m_rs, m_ls};
      m_ps = m_pp | (m_ps & ~sts_clr);
      m_rs = m_rp | (m_rs & ~sts_clr);
      m_ls = m_lp | (m_ls & ~sts_clr);
      np = '0; nr = '0; nl = '0;
      for (int c = 0; c < W; c++) begin
        bit lg;
        lg = m_lvl[c] && !m_ld[c] && tk && (ticks_in(m_pe[c], k) == LT);
        if (r[c] != m_lvl[c]) begin
          if (m_run[c] < 0) begin
            m_run[c] = k;
          end else if (tk && ticks_in(m_run[c], k) == DB) begin
            m_lvl[c] = r[c];
            m_run[c] = -1;
            if (r[c]) begin
              np[c] = 1'b1; m_pe[c] = k;
            end else begin
              nr[c] = 1'b1; m_ld[c] = 1'b0;
            end
          end
        end else begin
          m_run[c] = -1;
        end
        if (lg && !nr[c]) begin
          nl[c] = 1'b1; m_ld[c] = 1'b1;
        end
      end
      m_pp = np; m_rp = nr; m_lp = nl;
      k++;
    end
  end

  // Per-cycle comparison and event bookkeeping, 1 time unit after the edge.
  int n_press [W], n_rel [W], n_long [W];
  int t_press [W], t_rel [W], t_long [W];

  always @(posedge clk) begin
    #1;
    if (m_ok) begin
      check("lvl_pulses", {data_out, press_pulse, release_pulse, long_pulse}, {m_lvl, m_pp, m_rp, m_lp});
      check("sticky_irq", {press_sts, release_sts, long_sts, irq}, {m_ps, m_rs, m_ls, m_irq});
      for (int c = 0; c < W; c++) begin
        if (press_pulse[c] === 1'b1)   begin n_press[c]++; t_press[c] = cyc; end
        if (release_pulse[c] === 1'b1) begin n_rel[c]++;   t_rel[c]   = cyc; end
        if (long_pulse[c] === 1'b1)    begin n_long[c]++;  t_long[c]  = cyc; end
      end
    end
  end

  task automatic clr_mon();
    for (int c = 0; c < W; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
      t_press[c] = -100000; t_rel[c] = -100000; t_long[c] = -100000;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_all_sticky();
    sts_clr = '1;
    @(negedge clk);
    sts_clr = '0;
    wait_cyc(2);
  endtask

  int t0, t1, lat, found;
  int hold [W];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_mon();
    wait_cyc(3);
    reset = 1'b0;

    // Idle keys: nothing happens.
    clr_mon();
    wait_cyc(200);
    check("idle_pulses", n_press[0] + n_press[1] + n_rel[0] + n_rel[1] + n_long[0] + n_long[1], 0);
    check("idle_outs", {data_out, press_sts, release_sts, long_sts, irq}, 0);

    // Short low glitch is rejected.
    data_in[0] = 1'b0;
    wait_cyc(15);
    data_in[0] = 1'b1;
    wait_cyc(60);
    check("glitch_press", n_press[0], 0);
    check("glitch_lvl", data_out[0], 0);
    check("glitch_sts", press_sts[0], 0);

    // Full press, long press, release.
    clr_mon();
    data_in[0] = 1'b0; t0 = cyc;
    wait_cyc(200);
    data_in[0] = 1'b1; t1 = cyc;
    wait_cyc(60);
    check("press_cnt", n_press[0], 1);
    lat = t_press[0] - t0;
    check("press_lat", lat, clampi(lat, 23, 33));
    check("long_cnt", n_long[0], 1);
    lat = t_long[0] - t_press[0];
    check("long_lat", lat, clampi(lat, 70, 80));
    check("rel_cnt", n_rel[0], 1);
    lat = t_rel[0] - t1;
    check("rel_lat", lat, clampi(lat, 23, 33));
    check("rel_lvl", data_out[0], 0);
    check("ch1_silent", n_press[1] + n_rel[1] + n_long[1], 0);
    clear_all_sticky();

    // High glitch while pressed does not release, long still fires once.
    clr_mon();
    data_in[0] = 1'b0;
    wait_cyc(40);
    check("g2_press", n_press[0], 1);
    data_in[0] = 1'b1;
    wait_cyc(12);
    data_in[0] = 1'b0;
    wait_cyc(20);
    check("g2_no_rel", n_rel[0], 0);
    check("g2_lvl", data_out[0], 1);
    wait_cyc(80);
    check("g2_long", n_long[0], 1);
    data_in[0] = 1'b1;
    wait_cyc(50);
    check("g2_rel", n_rel[0], 1);
    check("g2_long_once", n_long[0], 1);
    clear_all_sticky();

    // Set beats clear; irq follows the last clear by one cycle.
    clr_mon();
    data_in = '0;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (press_pulse[0] === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("p0_seen", found, 1);
    sts_clr[0] = 1'b1;
    @(negedge clk);
    sts_clr[0] = 1'b0;
    check("set_wins", press_sts[0], 1);
    check("both_sts", press_sts[1], 1);
    wait_cyc(2);
    check("irq_on", irq, 1);
    sts_clr = 2'b01;
    @(negedge clk);
    sts_clr = '0;
    @(negedge clk);
    check("clr0_sts", press_sts[0], 0);
    check("irq_after_clr0", irq, 1);
    sts_clr = 2'b10;
    @(negedge clk);
    sts_clr = '0;
    check("clr1_sts", press_sts[1], 0);
    check("irq_lag", irq, 1);
    @(negedge clk);
    check("irq_off", irq, 0);

    // Reset while pressed: silent return to idle, then a normal press.
    check("pre_rst_lvl", data_out[0], 1);
    reset = 1'b1;
    data_in = '1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_outs", {data_out, press_sts, release_sts, long_sts, irq}, 0);
    clr_mon();
    wait_cyc(60);
    check("rst_no_rel", n_rel[0] + n_rel[1], 0);
    check("rst_no_press", n_press[0] + n_press[1], 0);
    data_in[0] = 1'b0;
    wait_cyc(50);
    check("repress", n_press[0], 1);
    check("repress_lvl", data_out[0], 1);
    data_in[0] = 1'b1;
    wait_cyc(50);

    // Random traffic on both channels with random clears and one reset.
    clr_mon();
    for (int c = 0; c < W; c++) hold[c] = $urandom_range(1, 70);
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      for (int c = 0; c < W; c++) begin
        if (hold[c] == 0) begin
          data_in[c] = ~data_in[c];
          hold[c] = $urandom_range(1, 70);
        end else begin
          hold[c]--;
        end
      end
      sts_clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      reset = (i == 1300);
    end
    reset = 1'b0;
    sts_clr = '0;
    data_in = '1;
    wait_cyc(60);
    check("rand_activity", (n_press[0] + n_press[1]) > 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
